// File: rtl/fpu_align_pkg.sv
// Shared constants for the FMA exponent-alignment datapath.
// Holds the opcode encoding and the default operand widths.
package fpu_align_pkg;

   localparam int DEF_EXP_W = 9;
   localparam int DEF_MAN_W = 48;

   typedef logic [1:0] opcode_t;

   localparam opcode_t OP_ADD = 2'b01;
   localparam opcode_t OP_SUB = 2'b10;

   function automatic logic op_is_valid(input opcode_t op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/fmadd_align_shifter.sv
// Combinational right-shift of the smaller-exponent mantissa.
// Produces the aligned mantissa plus guard/round/sticky.
module fmadd_align_shifter
   import fpu_align_pkg::*;
#(
   parameter int MAN_W = DEF_MAN_W,
   parameter int EXP_W = DEF_EXP_W
) (
   input  logic [MAN_W-1:0] man_in,
   input  logic [EXP_W-1:0] shamt,
   output logic [MAN_W-1:0] man_out,
   output logic             guard,
   output logic             round,
   output logic             sticky,
   output logic             align_zero
);

   localparam int          WIDE_W = 3 * MAN_W;
   localparam int unsigned SAT_SH = 2 * MAN_W;

   logic [WIDE_W-1:0] wide;

   // Extra MAN_W bits below the 2*MAN_W field catch bits shifted past it for sticky.
   always_comb begin
      wide       = {man_in, {(2 * MAN_W){1'b0}}} >> shamt;
      man_out    = wide[WIDE_W-1 -: MAN_W];
      guard      = wide[2*MAN_W-1];
      round      = wide[2*MAN_W-2];
      sticky     = |wide[2*MAN_W-3:0];
      if (32'(shamt) >= SAT_SH) begin
         man_out = '0;
         guard   = 1'b0;
         round   = 1'b0;
         sticky  = |man_in;
      end
      align_zero = ~|man_out;
   end

endmodule

// File: rtl/fmadd_exp_align_pipe.sv
// Two-stage exponent compare / mantissa alignment pipeline for FMA add/sub.
// out_man_a carries the larger-exponent mantissa (A on ties), out_man_b the shifted one.
module fmadd_exp_align_pipe
   import fpu_align_pkg::*;
#(
   parameter int EXP_W = DEF_EXP_W,
   parameter int MAN_W = DEF_MAN_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sign_a,
   input  logic             in_sign_b,
   input  logic [EXP_W-1:0] in_exp_a,
   input  logic [EXP_W-1:0] in_exp_b,
   input  logic [MAN_W-1:0] in_man_a,
   input  logic [MAN_W-1:0] in_man_b,
   input  logic [1:0]       in_opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [MAN_W-1:0] out_man_a,
   output logic [MAN_W-1:0] out_man_b,
   output logic [EXP_W-1:0] out_exp,
   output logic             out_sign,
   output logic             out_eff_add,
   output logic             out_eff_sub,
   output logic             out_a_gt_b,
   output logic             out_guard,
   output logic             out_round,
   output logic             out_sticky,
   output logic             out_align_zero,
   output logic             out_op_err
);

   typedef struct packed {
      logic             sign;
      logic             eff_add;
      logic             eff_sub;
      logic             a_gt_b;
      logic             op_err;
      logic [EXP_W-1:0] exp;
      logic [EXP_W-1:0] shamt;
      logic [MAN_W-1:0] man_big;
      logic [MAN_W-1:0] man_small;
   } s1_t;

   typedef struct packed {
      logic             sign;
      logic             eff_add;
      logic             eff_sub;
      logic             a_gt_b;
      logic             op_err;
      logic             guard;
      logic             round;
      logic             sticky;
      logic             align_zero;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man_a;
      logic [MAN_W-1:0] man_b;
   } s2_t;

   logic v1_q, v1_d, v2_q, v2_d;
   s1_t  s1_q, s1_d;
   s2_t  s2_q, s2_d;

   logic ge, gt, exp_eq, mge, sign_x, eff_add_raw, eff_sub_raw, op_ok, a_wins;
   logic drain2;

   logic [MAN_W-1:0] sh_man;
   logic             sh_guard, sh_round, sh_sticky, sh_zero;

   assign drain2   = ~v2_q | out_ready;
   assign in_ready = ~v1_q | drain2;

   // Stage 1: compare, pick the larger operand and form the shift distance.
   always_comb begin
      ge          = in_exp_a >= in_exp_b;
      gt          = in_exp_a > in_exp_b;
      exp_eq      = in_exp_a == in_exp_b;
      mge         = in_man_a >= in_man_b;
      sign_x      = in_sign_a ^ in_sign_b;
      eff_sub_raw = (sign_x & in_opcode[0]) | (~sign_x & in_opcode[1]);
      eff_add_raw = (sign_x & in_opcode[1]) | (~sign_x & in_opcode[0]);
      op_ok       = op_is_valid(in_opcode);
      a_wins      = gt | (exp_eq & mge);

      v1_d = v1_q;
      s1_d = s1_q;
      if (in_ready) begin
         v1_d = in_valid;
         if (in_valid) begin
            s1_d.sign      = (eff_add_raw | a_wins) ? in_sign_a : (in_sign_b ^ in_opcode[1]);
            s1_d.eff_add   = eff_add_raw & op_ok;
            s1_d.eff_sub   = eff_sub_raw & op_ok;
            s1_d.a_gt_b    = a_wins;
            s1_d.op_err    = ~op_ok;
            s1_d.exp       = ge ? in_exp_a : in_exp_b;
            s1_d.shamt     = ge ? (in_exp_a - in_exp_b) : (in_exp_b - in_exp_a);
            s1_d.man_big   = ge ? in_man_a : in_man_b;
            s1_d.man_small = ge ? in_man_b : in_man_a;
         end
      end
   end

   fmadd_align_shifter #(
      .MAN_W (MAN_W),
      .EXP_W (EXP_W)
   ) u_shifter (
      .man_in     (s1_q.man_small),
      .shamt      (s1_q.shamt),
      .man_out    (sh_man),
      .guard      (sh_guard),
      .round      (sh_round),
      .sticky     (sh_sticky),
      .align_zero (sh_zero)
   );

   // Stage 2 only reloads when empty or its current result is being taken.
   always_comb begin
      v2_d = v2_q;
      s2_d = s2_q;
      if (drain2) begin
         v2_d = v1_q;
         if (v1_q) begin
            s2_d.sign       = s1_q.sign;
            s2_d.eff_add    = s1_q.eff_add;
            s2_d.eff_sub    = s1_q.eff_sub;
            s2_d.a_gt_b     = s1_q.a_gt_b;
            s2_d.op_err     = s1_q.op_err;
            s2_d.guard      = sh_guard;
            s2_d.round      = sh_round;
            s2_d.sticky     = sh_sticky;
            s2_d.align_zero = sh_zero;
            s2_d.exp        = s1_q.exp;
            s2_d.man_a      = s1_q.man_big;
            s2_d.man_b      = sh_man;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         v1_q <= v1_d;
         v2_q <= v2_d;
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign out_valid      = v2_q;
   assign out_man_a      = s2_q.man_a;
   assign out_man_b      = s2_q.man_b;
   assign out_exp        = s2_q.exp;
   assign out_sign       = s2_q.sign;
   assign out_eff_add    = s2_q.eff_add;
   assign out_eff_sub    = s2_q.eff_sub;
   assign out_a_gt_b     = s2_q.a_gt_b;
   assign out_guard      = s2_q.guard;
   assign out_round      = s2_q.round;
   assign out_sticky     = s2_q.sticky;
   assign out_align_zero = s2_q.align_zero;
   assign out_op_err     = s2_q.op_err;

endmodule

// File: doc/fmadd_exp_align_pipe.md
FMADD_EXP_ALIGN_PIPE -- requirements
Module: fmadd_exp_align_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 9: exponent width in bits.
REQ-002 SHALL have parameter MAN_W, default 48: width of the product-format mantissa in bits.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have ports in_valid input 1 and in_ready output 1: input handshake.
REQ-006 SHALL have ports in_sign_a and in_sign_b, input, 1 each: operand signs.
REQ-007 SHALL have ports in_exp_a and in_exp_b, input, EXP_W each: biased exponents.
REQ-008 SHALL have ports in_man_a and in_man_b, input, MAN_W each: mantissas.
REQ-009 SHALL have port in_opcode, input, 2: one-hot operation; bit0 = add, bit1 = sub.
REQ-010 SHALL have ports out_valid output 1 and out_ready input 1: output handshake.
REQ-011 SHALL have ports out_man_a and out_man_b, output, MAN_W each: aligned mantissas.
REQ-012 SHALL have port out_exp, output, EXP_W: the larger exponent.
REQ-013 SHALL have 1-bit outputs out_sign, out_eff_add, out_eff_sub, out_a_gt_b, out_guard, out_round, out_sticky, out_align_zero and out_op_err.

Function
REQ-014 SHALL be a 2-stage pipeline with latency 2 cycles: stage 1 registers compare, select and shift amount; stage 2 registers the shift result and G/R/S.
REQ-015 SHALL accept an input on in_valid & in_ready, and retire an output on out_valid & out_ready.
REQ-016 SHALL drive in_ready = ~v1 | ~v2 | out_ready, where v1 and v2 are the stage valid bits; each stage loads only when its slot is empty or being drained.
REQ-017 SHALL, while out_valid & ~out_ready, hold every out_* signal stable.
REQ-018 SHALL preserve transaction order, with no loss or duplication under any in_valid/out_ready pattern.
REQ-019 SHALL sustain one transaction per cycle when out_ready is held high.
REQ-020 SHALL compute ge = exp_a >= exp_b, gt = exp_a > exp_b, and mge = man_a >= man_b, all unsigned.
REQ-021 SHALL compute eff_sub = (sa^sb)&op[0] | ~(sa^sb)&op[1] and eff_add = (sa^sb)&op[1] | ~(sa^sb)&op[0].
REQ-022 SHALL set out_sign = sign_a when eff_add, gt, or (exp equal & mge); otherwise out_sign = sign_b ^ op[1].
REQ-023 SHALL set out_a_gt_b = gt | (exp equal & mge).
REQ-024 SHALL set out_exp = max(exp_a, exp_b).
REQ-025 SHALL set shift amount d = |exp_a - exp_b| in EXP_W bits.
REQ-026 SHALL pass the larger-exponent mantissa through unshifted; A is the larger on ties.
REQ-027 SHALL right-shift the other mantissa by d, taken from the top MAN_W bits of a 2*MAN_W extended field.
REQ-028 SHALL set guard = extended bit MAN_W-1, round = bit MAN_W-2, and sticky = OR of bits MAN_W-3..0 plus any bits shifted beyond the extended field.
REQ-029 SHALL, when d >= 2*MAN_W, output the shifted mantissa as 0, guard = 0, round = 0, and sticky = OR of the original shifted mantissa.
REQ-030 SHALL set out_align_zero = 1 when the shifted mantissa output is all zero.
REQ-031 SHALL, for in_opcode 00 or 11, set out_op_err = 1 and force out_eff_add = 0 and out_eff_sub = 0; all other outputs follow the rules above.

Reset
REQ-032 SHALL, on rst high, clear v1 and v2 immediately, discarding any in-flight transactions.
REQ-033 SHALL hold all out_* at 0 during reset, including out_valid = 0.
REQ-034 SHALL drive in_ready = 1 from the first clk edge after rst deasserts.

Structure
REQ-035 SHALL take opcode constants (OP_ADD = 01, OP_SUB = 10) and default EXP_W/MAN_W from shared package fpu_align_pkg.
REQ-036 SHALL implement the shift and G/R/S generation in combinational sub-module fmadd_align_shifter, parametrised by MAN_W and EXP_W.

Verification
REQ-037 SHALL cover: exp_a=0x085, exp_b=0x083, man_b=0x800000000000, op=01, same signs -> out_man_b=0x200000000000, G=R=S=0, out_exp=0x085, eff_add=1, 2 cycles after accept.
REQ-038 SHALL cover: exp equal 0x080, man_a=0x400000000000, man_b=0x600000000000, sa=0, sb=0, op=10 -> eff_sub=1, out_a_gt_b=0, out_sign=1.
REQ-039 SHALL cover: exp_a=0x0C0, exp_b=0x080 (d=64), man_b=0x000000000001 -> out_man_b=0, out_align_zero=1, G=R=0, S=1.
REQ-040 SHALL cover: out_ready=0 for 4 cycles with in_valid=1 -> exactly 2 accepted, in_ready=0 afterwards, outputs stable, in-order drain once out_ready=1.
REQ-041 SHALL cover: rst pulse with both stages full -> out_valid=0 the same cycle, and no stale output after reset.
REQ-042 SHALL cover: op=11 -> out_op_err=1, eff_add=0, eff_sub=0.
